fmap_frame_assembler: RTL and testbench



---
 rtl/fmap_frame_assembler.sv | 107 ++++++++++
 tb/tb_fmap_frame_assembler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_frame_assembler.sv
// fmap_frame_assembler: packs a serial FP16 element stream into one flat
// H*W*D frame for the max-pool stage and holds it until acknowledged.
// Optional build macro FMAP_LAST_CHECK_EN adds in_last/frame_err framing checks.
module fmap_frame_assembler #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 2,
  parameter int H          = 13,
  parameter int W          = 13
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
`ifdef FMAP_LAST_CHECK_EN
  input  logic                              in_last,
`endif
  output logic                              in_ready,
  output logic [0:H*W*D*DATA_WIDTH-1]       frame_data,
  output logic                              frame_valid,
`ifdef FMAP_LAST_CHECK_EN
  output logic                              frame_err,
`endif
  input  logic                              frame_ack
);

  localparam int N    = H * W * D;
  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   widx, widx_nxt;
  logic              accept;
  logic              at_last;

  assign at_last = (widx == LAST_IDX);

  // Next-state, write-index and handshake decode from the registered state
  always_comb begin
    state_nxt   = state;
    widx_nxt    = widx;
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      FILL: begin
        in_ready = !reset;
        accept   = in_valid && !reset;
        if (accept) begin
          if (at_last) begin
            widx_nxt  = '0;
            state_nxt = FULL;
          end
`ifdef FMAP_LAST_CHECK_EN
          // Early in_last: resync to the start of a new frame, discard this one
          else if (in_last) begin
            widx_nxt = '0;
          end
`endif
          else begin
            widx_nxt = widx + 1'b1;
          end
        end
      end
      FULL: begin
        frame_valid = 1'b1;
        if (frame_ack) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Control state: FSM state and write index
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      widx  <= '0;
    end else begin
      state <= state_nxt;
      widx  <= widx_nxt;
    end
  end

  // Frame storage: element widx captured on each accepted beat, held while FULL
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_data <= '0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (widx == IDXW'(k)) frame_data[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
      end
    end
  end

`ifdef FMAP_LAST_CHECK_EN
  // Sticky framing error: in_last must coincide exactly with the final element
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else if (accept && (in_last != at_last)) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fmap_frame_assembler.sv
// Scoreboard bench for fmap_frame_assembler: stimulus pushes expected frames,
// a monitor pops and compares on each frame_valid rise.
module tb_fmap_frame_assembler;

  localparam int DW = 16;
  localparam int N  = 13 * 13 * 2;
  localparam int FW = N * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:FW-1] frame_data;
  logic          frame_valid;
  logic          frame_ack = 1'b0;
`ifdef FMAP_LAST_CHECK_EN
  logic          in_last = 1'b0;
  logic          frame_err;
`endif

  fmap_frame_assembler dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
`ifdef FMAP_LAST_CHECK_EN
    .in_last     (in_last),
    .frame_err   (frame_err),
`endif
    .in_ready    (in_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_pass = 0;
  int            n_total = 0;
  logic [0:FW-1] exp_q[$];
  logic [0:FW-1] cur_exp;
  logic [DW-1:0] elem[N];
  int            acc_cnt = 0;
  int            last_acc_cyc = -10;
  bit            fv_prev = 1'b0;

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic logic [0:FW-1] pack_frame();
    logic [0:FW-1] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = elem[k];
    return v;
  endfunction

  function automatic void chk_frame(input string name, input logic [0:FW-1] exp);
    int bad;
    bad = -1;
    for (int k = 0; k < N; k++) begin
      if (bad < 0 && frame_data[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    end
    if (bad < 0) chk(1'b1, name, 0, 0);
    else chk(1'b0, $sformatf("%s elem %0d", name, bad),
             longint'(frame_data[bad*DW +: DW]), longint'(exp[bad*DW +: DW]));
  endfunction

  // Monitor: counts accepted beats and checks each presented frame
  initial begin
    logic [0:FW-1] e;
    forever begin
      @(negedge clk);
      if (reset) acc_cnt = 0;
      else if (in_valid && in_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
`ifdef FMAP_LAST_CHECK_EN
        if (in_last && acc_cnt != N) acc_cnt = 0;
`endif
      end
      if (frame_valid && !fv_prev) begin
        chk(acc_cnt == N, "beats_before_frame_valid", acc_cnt, N);
        chk(cyc == last_acc_cyc + 1, "frame_valid_latency", cyc - last_acc_cyc, 1);
        if (exp_q.size() == 0) chk(1'b0, "unexpected_frame", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk_frame("frame_data", e);
        end
        acc_cnt = 0;
      end
      fv_prev = frame_valid;
    end
  end

  task automatic send_beats(input int first, input int count, input bit bubbles,
                            input int ack_from = -1, input int ack_to = -1,
                            input int last_at = N - 1);
    for (int k = first; k < first + count; k++) begin
      int t;
      bit ok;
      if (bubbles && $urandom_range(1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data   = elem[k];
      in_valid  = 1'b1;
      frame_ack = (k >= ack_from && k <= ack_to);
`ifdef FMAP_LAST_CHECK_EN
      in_last = (k == last_at);
`endif
      t = 0;
      forever begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        if (ok) break;
        t++;
        if (t > 20) begin
          $display("FAIL beat_accept_timeout: beat %0d not accepted, in_ready %0b, expected 1", k, in_ready);
          $fatal(1);
        end
      end
    end
    in_valid  = 1'b0;
    frame_ack = 1'b0;
`ifdef FMAP_LAST_CHECK_EN
    in_last = 1'b0;
`endif
    if (last_at < 0) in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk(in_ready == 1'b0, "in_ready_during_reset", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk(frame_valid == 1'b0, "reset_frame_valid", frame_valid, 0);
    chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
    chk_frame("reset_frame_data_zero", '0);
  endtask

  task automatic finish_frame(input string tag, input bit hold);
    int t;
    t = 0;
    while (!frame_valid && t < 5) begin
      @(posedge clk); #1;
      t++;
    end
    chk(frame_valid === 1'b1, {tag, "_frame_valid"}, frame_valid, 1);
    chk(in_ready === 1'b0, {tag, "_in_ready_full"}, in_ready, 0);
    if (hold) begin
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        in_data = 16'(16'h7000 + i);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk(acc_cnt == 0, {tag, "_hold_no_beats"}, acc_cnt, 0);
      chk(frame_valid === 1'b1, {tag, "_hold_frame_valid"}, frame_valid, 1);
      chk_frame({tag, "_hold_frame_data"}, cur_exp);
    end
    @(negedge clk);
    @(posedge clk); #1;
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    chk(frame_valid === 1'b0, {tag, "_ack_frame_valid"}, frame_valid, 0);
    chk(in_ready === 1'b1, {tag, "_ack_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Basic frame with two marked elements, then hold and ack
    for (int k = 0; k < N; k++) elem[k] = 16'h4000;
    elem[20]  = 16'h4500;
    elem[190] = 16'h4200;
    cur_exp = pack_frame();
    exp_q.push_back(cur_exp);
    send_beats(0, N, 1'b0);
    chk(frame_data[320 +: 16] == 16'h4500, "basic_elem20", frame_data[320 +: 16], 16'h4500);
    chk(frame_data[3040 +: 16] == 16'h4200, "basic_elem190", frame_data[3040 +: 16], 16'h4200);
    chk(frame_data[0 +: 16] == 16'h4000, "basic_elem0", frame_data[0 +: 16], 16'h4000);
    finish_frame("basic", 1'b1);

    // Bubbled stream with index-coded data
    for (int k = 0; k < N; k++) elem[k] = 16'(16'h3C00 + k);
    exp_q.push_back(pack_frame());
    send_beats(0, N, 1'b1);
    chk(frame_data[0 +: 16] == 16'h3C00, "bubble_elem0", frame_data[0 +: 16], 16'h3C00);
    chk(frame_data[337*16 +: 16] == 16'h3D51, "bubble_elem337", frame_data[337*16 +: 16], 16'h3D51);
    finish_frame("bubble", 1'b0);

    // Partial frame discarded by reset, then a clean frame
    for (int k = 0; k < N; k++) elem[k] = 16'h1234;
    send_beats(0, 100, 1'b0);
    do_reset();
    for (int k = 0; k < N; k++) elem[k] = 16'h3800;
    exp_q.push_back(pack_frame());
    send_beats(0, N, 1'b0);
    finish_frame("post_reset", 1'b0);

    // frame_ack asserted during beats 5..9 while filling
    for (int k = 0; k < N; k++) elem[k] = 16'h5000 ^ 16'(k);
    exp_q.push_back(pack_frame());
    send_beats(0, N, 1'b0, 5, 9);
    finish_frame("spurious_ack", 1'b0);

`ifdef FMAP_LAST_CHECK_EN
    chk(frame_err == 1'b0, "err_clean_so_far", frame_err, 0);
    for (int k = 0; k < N; k++) elem[k] = 16'h2C00;
    send_beats(0, 200, 1'b0, -1, -1, 199);
    repeat (3) begin @(posedge clk); #1; end
    chk(frame_err == 1'b1, "err_early_last", frame_err, 1);
    chk(frame_valid == 1'b0, "err_no_frame_valid", frame_valid, 0);
    exp_q.push_back(pack_frame());
    send_beats(0, N, 1'b0);
    finish_frame("after_err", 1'b0);
    chk(frame_err == 1'b1, "err_sticky", frame_err, 1);
    do_reset();
    chk(frame_err == 1'b0, "err_cleared_by_reset", frame_err, 0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk(exp_q.size() == 0, "all_frames_presented", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
